data_memory: RTL
================

// Module: data_memory
// PURPOSE
//  Data-memory responder for the datapath's dm_* interface: services word
//  loads/stores issued by the core (dm_we, dm_address, dm_d) and returns dm_q.
//  The access is multicycle, with programmable wait states and a req/ready
//  handshake, so the core can stall on memory. Sits beside the datapath and
//  replaces the ideal combinational memory.
// PARAMETERS
//  DATA_W       32    data word width
//  ADDR_W       16    dm_address width (word address)
//  DEPTH        1024  number of words implemented (power of two)
//  WAIT_STATES  2     extra cycles between request capture and dm_ready (0..15)
// PORTS
//  clk         in   1       single clock; all state updates on rising edge
//  rst_n       in   1       synchronous, active-low reset
//  dm_req      in   1       request strobe, sampled only in IDLE
//  dm_we       in   1       1 = store, 0 = load; sampled with dm_req
//  dm_address  in   ADDR_W  word address; sampled with dm_req
//  dm_d        in   DATA_W  store data; sampled with dm_req
//  dm_q        out  DATA_W  load data, registered; valid when dm_ready=1
//  dm_ready    out  1       one-cycle completion pulse (load and store)
//  dm_busy     out  1       1 while a request is outstanding (state != IDLE)
//  dm_err      out  1       pulses with dm_ready when the address is out of range
// BEHAVIOUR
//  - Reset: state=IDLE; dm_q=0, dm_ready=0, dm_busy=0, dm_err=0. Array contents
//    are not reset. Reset mid-access abandons the request; a pending store is
//    NOT committed.
//  - FSM: IDLE --dm_req--> WAIT (WAIT_STATES>0) or RESP (WAIT_STATES=0).
//    WAIT: down-counter loaded with WAIT_STATES-1; -> RESP when it reaches 0.
//    RESP: lasts exactly 1 cycle, then -> IDLE. dm_ready=1 only in RESP.
//  - Latency: request sampled at edge N; dm_ready high in cycle N+1+WAIT_STATES.
//    A new request can be sampled in the cycle after RESP (dm_ready low).
//  - dm_req during WAIT/RESP is ignored; the initiator must hold off while
//    dm_busy=1. A request is never queued.
//  - Capture: we/address/data are latched at the IDLE->(WAIT|RESP) edge;
//    input changes afterwards have no effect.
//  - Index = dm_address[$clog2(DEPTH)-1:0]. Any set bit above that is out of
//    range: store is dropped, load returns 0, dm_err=1 with dm_ready.
//  - Store commits to the array on the edge that ends RESP; dm_q unchanged.
//  - Load: array read during the final WAIT cycle (or the capture edge if
//    WAIT_STATES=0); dm_q updated on entry to RESP and held until the next
//    load completes or reset.
//  - Load immediately after a store to the same index returns the new data.
//  - dm_busy=1 in WAIT and RESP.
// CONFIGURATION
//  DM_BYTE_LANES_EN defined: adds input port dm_be [DATA_W/8-1:0], sampled with
//    dm_req. A store writes only the lanes with be=1 (read-modify-write merge
//    inside the array). be=0 stores leave the word unchanged. Loads ignore be.
//  Not defined: the port is absent and every store writes the full word.
// STRUCTURE
//  - Package dm_pkg: typedef enum {DM_IDLE, DM_WAIT, DM_RESP} dm_state_t;
//    localparam DM_CNT_W=4.
//  - Sub-module dm_ram_array: synchronous single-port DEPTH x DATA_W array
//    (we, index, wdata, optional lane mask, registered rdata). The FSM,
//    counter and range check live in data_memory.
// TESTING (DEPTH=1024, WAIT_STATES=2 unless noted)
//  1 Reset: hold rst_n=0 for 3 cycles with dm_req=1 -> dm_ready/busy/err/q all 0.
//  2 Store 0xDEADBEEF @0x0010, then load @0x0010 -> store ready 3 cycles after
//    capture; load dm_q=0xDEADBEEF with dm_ready, busy=1 for 3 cycles each.
//  3 WAIT_STATES=0: back-to-back loads @1,@2 -> ready in every 2nd cycle,
//    requests in RESP ignored.
//  4 Store @0x0400 (out of range) then load @0x0400 -> dm_err=1 both;
//    load dm_q=0; word @0x0000 unchanged.
//  5 Store 0x11111111 @5, assert rst_n=0 during WAIT, load @5 -> old contents,
//    not 0x11111111.
//  6 DM_BYTE_LANES_EN: store 0xAABBCCDD @7, store 0x000000EE with be=4'b0001 ->
//    load @7 returns 0xAABBCCEE.

Source files
------------

// File: rtl/dm_pkg.sv
// Shared types for the multicycle data-memory responder.
package dm_pkg;
  typedef enum logic [1:0] {DM_IDLE, DM_WAIT, DM_RESP} dm_state_t;
  localparam int DM_CNT_W = 4;
endpackage

// File: rtl/dm_ram_array.sv
// Synchronous single-port word array with per-byte write mask and registered read.
// rclr forces the read register to zero (out-of-range loads, reset).
module dm_ram_array #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 1024
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     we,
  input  logic                     re,
  input  logic                     rclr,
  input  logic [$clog2(DEPTH)-1:0] index,
  input  logic [DATA_W-1:0]        wdata,
  input  logic [DATA_W/8-1:0]      be,
  output logic [DATA_W-1:0]        rdata
);
  localparam int LANES = DATA_W / 8;

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      for (int l = 0; l < LANES; l++) begin
        if (be[l]) mem[index][l*8 +: 8] <= wdata[l*8 +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n || rclr) rdata <= '0;
    else if (re)        rdata <= mem[index];
  end
endmodule

// File: rtl/data_memory.sv
// Multicycle data memory with req/ready handshake and programmable wait states.
// Define DM_BYTE_LANES_EN to add the dm_be byte-lane store mask.
module data_memory
  import dm_pkg::*;
#(
  parameter int DATA_W      = 32,
  parameter int ADDR_W      = 16,
  parameter int DEPTH       = 1024,
  parameter int WAIT_STATES = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              dm_req,
  input  logic              dm_we,
  input  logic [ADDR_W-1:0] dm_address,
  input  logic [DATA_W-1:0] dm_d,
`ifdef DM_BYTE_LANES_EN
  input  logic [DATA_W/8-1:0] dm_be,
`endif
  output logic [DATA_W-1:0] dm_q,
  output logic              dm_ready,
  output logic              dm_busy,
  output logic              dm_err
);
  localparam int  IDX_W     = $clog2(DEPTH);
  localparam int  LANES     = DATA_W / 8;
  localparam bit  ZERO_WAIT = (WAIT_STATES == 0);

  dm_state_t           state;
  logic [DM_CNT_W-1:0] cnt;
  logic                we_reg;
  logic                oor_reg;
  logic [IDX_W-1:0]    idx_reg;
  logic [DATA_W-1:0]   d_reg;
  logic [LANES-1:0]    be_reg;
  logic [LANES-1:0]    be_in;
  logic                in_range;
  logic                accept;
  logic                last_wait;
  logic                ram_we;
  logic                ram_re;
  logic                ram_rclr;
  logic [IDX_W-1:0]    ram_index;

`ifdef DM_BYTE_LANES_EN
  assign be_in = dm_be;
`else
  assign be_in = '1;
`endif

  assign in_range  = (dm_address >> IDX_W) == '0;
  assign accept    = (state == DM_IDLE) && dm_req;
  assign last_wait = (state == DM_WAIT) && (cnt == '0);

  // The read lands in the registered rdata exactly as the FSM enters RESP.
  assign ram_re    = (ZERO_WAIT && accept && !dm_we && in_range) ||
                     (last_wait && !we_reg && !oor_reg);
  assign ram_rclr  = (ZERO_WAIT && accept && !dm_we && !in_range) ||
                     (last_wait && !we_reg && oor_reg);
  assign ram_we    = rst_n && (state == DM_RESP) && we_reg && !oor_reg;
  assign ram_index = (state == DM_IDLE) ? dm_address[IDX_W-1:0] : idx_reg;

  always_ff @(posedge clk) begin
    if (accept) begin
      we_reg  <= dm_we;
      oor_reg <= !in_range;
      idx_reg <= dm_address[IDX_W-1:0];
      d_reg   <= dm_d;
      be_reg  <= be_in;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= DM_IDLE;
      cnt      <= '0;
      dm_ready <= 1'b0;
      dm_busy  <= 1'b0;
      dm_err   <= 1'b0;
    end else begin
      dm_ready <= 1'b0;
      dm_err   <= 1'b0;
      case (state)
        DM_IDLE: begin
          if (dm_req) begin
            dm_busy <= 1'b1;
            cnt     <= DM_CNT_W'(WAIT_STATES - 1);
            if (ZERO_WAIT) begin
              state    <= DM_RESP;
              dm_ready <= 1'b1;
              dm_err   <= !in_range;
            end else begin
              state <= DM_WAIT;
            end
          end
        end
        DM_WAIT: begin
          if (cnt == '0) begin
            state    <= DM_RESP;
            dm_ready <= 1'b1;
            dm_err   <= oor_reg;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        DM_RESP: begin
          state   <= DM_IDLE;
          dm_busy <= 1'b0;
        end
        default: state <= DM_IDLE;
      endcase
    end
  end

  dm_ram_array #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_ram (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (ram_we),
    .re    (ram_re),
    .rclr  (ram_rclr),
    .index (ram_index),
    .wdata (d_reg),
    .be    (be_reg),
    .rdata (dm_q)
  );
endmodule
